// File: rtl/fpu_rsp_arbiter.sv
// fpu_rsp_arbiter
// Merges responses from the FPU compute units (FMA, DIV/SQRT, CVT, NCP) into a
// single stream towards commit. A round-robin arbiter picks one valid unit per
// cycle and writes its response into a 2-entry elastic buffer. The buffer head
// drives the output.
//
// Handshake: a transfer happens on a channel in any cycle where valid and ready
// are both high. A producer holds valid and data stable until it is accepted.
// A producer never waits for ready before raising valid. The ready_in grant
// depends only on registered state (buffer occupancy, rr pointer), on valid_in
// and on reset. It never depends on ready_out, so no combinational path runs
// from ready_out to ready_in.
//
// Optional feature: define FPU_RSP_ARB_PERF_EN to add the perf_stalls and
// perf_conflicts counter outputs. The datapath is the same with or without it.

module fpu_rsp_arbiter #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_LANES     = 1,
    parameter int TAG_WIDTH     = 1,
    parameter int PERF_CTR_BITS = 44,
    localparam int SEL_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int RES_W        = NUM_LANES * 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           valid_in,
    output logic [NUM_INPUTS-1:0]           ready_in,
    input  logic [NUM_INPUTS*RES_W-1:0]     result_in,
    input  logic [NUM_INPUTS-1:0]           has_fflags_in,
    input  logic [NUM_INPUTS*5-1:0]         fflags_in,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0] tag_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [RES_W-1:0]                result_out,
    output logic                            has_fflags_out,
    output logic [4:0]                      fflags_out,
    output logic [TAG_WIDTH-1:0]            tag_out,
`ifdef FPU_RSP_ARB_PERF_EN
    output logic [SEL_W-1:0]                sel_out,
    output logic [PERF_CTR_BITS-1:0]        perf_stalls,
    output logic [PERF_CTR_BITS-1:0]        perf_conflicts
`else
    output logic [SEL_W-1:0]                sel_out
`endif
);

    // Round-robin pointer: the unit with the highest priority in the next scan.
    logic [SEL_W-1:0] ptr;

    // Buffer state. count is the occupancy (0..2). rd_ptr and wr_ptr pick the slot.
    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;

    // Buffer storage, two slots.
    logic [RES_W-1:0]     res_q   [2];
    logic                 hff_q   [2];
    logic [4:0]           ff_q    [2];
    logic [TAG_WIDTH-1:0] tag_q   [2];
    logic [SEL_W-1:0]     sel_q   [2];

    // Arbitration results.
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr_next;
    int               scan_idx;

    logic             space;
    logic             push;
    logic             pop;

    // Selected unit payload.
    logic [RES_W-1:0]     grant_res;
    logic                 grant_hff;
    logic [4:0]           grant_ff;
    logic [TAG_WIDTH-1:0] grant_tag;

    // Space comes only from registered occupancy. A pop in this cycle does not free a slot until the next cycle.
    assign space = (count < 2'd2);

    // Scan the units from ptr upward with wrap-around, and grant the first valid one.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NUM_INPUTS) begin
                scan_idx = scan_idx - NUM_INPUTS;
            end
            if (!grant_found && valid_in[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[SEL_W-1:0];
            end
        end
    end

    // After a grant, priority moves to the unit just past the winner, wrapping to 0.
    always_comb begin
        if (int'(grant_idx) >= NUM_INPUTS - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    // Accept only the granted unit, and only when a slot is free and reset is not active.
    always_comb begin
        ready_in = '0;
        if (grant_found && space && !reset) begin
            ready_in[grant_idx] = 1'b1;
        end
    end

    // Pick the granted unit's payload out of the flat input buses.
    always_comb begin
        grant_res = result_in[int'(grant_idx)*RES_W +: RES_W];
        grant_hff = has_fflags_in[grant_idx];
        grant_ff  = fflags_in[int'(grant_idx)*5 +: 5];
        grant_tag = tag_in[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
    end

    assign push = grant_found && space && !reset;
    assign pop  = valid_out && ready_out;

    // Output side: the head slot drives the outputs and stays stable until popped.
    assign valid_out      = (count != 2'd0);
    assign result_out     = res_q[rd_ptr];
    assign has_fflags_out = hff_q[rd_ptr];
    assign fflags_out     = ff_q[rd_ptr];
    assign tag_out        = tag_q[rd_ptr];
    assign sel_out        = sel_q[rd_ptr];

    // Buffer pointers, occupancy and rr pointer. Reset discards in-flight entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            ptr    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                ptr    <= ptr_next;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage. It is cleared on reset so the data outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                res_q[s] <= '0;
                hff_q[s] <= 1'b0;
                ff_q[s]  <= '0;
                tag_q[s] <= '0;
                sel_q[s] <= '0;
            end
        end else if (push) begin
            res_q[wr_ptr] <= grant_res;
            hff_q[wr_ptr] <= grant_hff;
            ff_q[wr_ptr]  <= grant_ff;
            tag_q[wr_ptr] <= grant_tag;
            sel_q[wr_ptr] <= grant_idx;
        end
    end

`ifdef FPU_RSP_ARB_PERF_EN
    int  valid_cnt;
    logic conflict;

    // Flag cycles where two or more units compete for the buffer.
    always_comb begin
        valid_cnt = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (valid_in[k]) begin
                valid_cnt = valid_cnt + 1;
            end
        end
        conflict = (valid_cnt >= 2);
    end

    // Count output back-pressure cycles and input contention cycles. Both counters wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls    <= '0;
            perf_conflicts <= '0;
        end else begin
            if (valid_out && !ready_out) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
            if (conflict) begin
                perf_conflicts <= perf_conflicts + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_rsp_arbiter.sv
// tb_fpu_rsp_arbiter
// Directed bench for fpu_rsp_arbiter with 4 units, 1 lane and 4-bit tags.
// Inputs change 1 ns after the rising edge. Outputs are compared on the falling edge.
// Perf counter checks are compiled in when FPU_RSP_ARB_PERF_EN is defined.

module tb_fpu_rsp_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   valid_in;
    logic [N-1:0]   ready_in;
    logic [N*32-1:0] result_in;
    logic [N-1:0]   has_fflags_in;
    logic [N*5-1:0] fflags_in;
    logic [N*TW-1:0] tag_in;
    logic           valid_out;
    logic           ready_out;
    logic [31:0]    result_out;
    logic           has_fflags_out;
    logic [4:0]     fflags_out;
    logic [TW-1:0]  tag_out;
    logic [1:0]     sel_out;
`ifdef FPU_RSP_ARB_PERF_EN
    logic [43:0]    perf_stalls;
    logic [43:0]    perf_conflicts;
`endif

    int passed;
    int total;

    fpu_rsp_arbiter #(
        .NUM_INPUTS(N), .NUM_LANES(1), .TAG_WIDTH(TW), .PERF_CTR_BITS(44)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in),
        .result_in(result_in), .has_fflags_in(has_fflags_in),
        .fflags_in(fflags_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .result_out(result_out), .has_fflags_out(has_fflags_out),
        .fflags_out(fflags_out), .tag_out(tag_out),
`ifdef FPU_RSP_ARB_PERF_EN
        .sel_out(sel_out),
        .perf_stalls(perf_stalls), .perf_conflicts(perf_conflicts)
`else
        .sel_out(sel_out)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic [31:0] r, input logic hf,
                            input logic [4:0] f, input logic [TW-1:0] t);
        result_in[u*32 +: 32]  = r;
        has_fflags_in[u]       = hf;
        fflags_in[u*5 +: 5]    = f;
        tag_in[u*TW +: TW]     = t;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        valid_in  = '0;
        ready_out = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Reset values and the first single response
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL rst_valid_out: got %b expected 0", valid_out); else passed++;
        total++; if (ready_in !== 4'b0000) $display("FAIL rst_ready_in: got %b expected 0000", ready_in); else passed++;
        total++; if (result_out !== 32'h0) $display("FAIL rst_result_out: got %h expected 0", result_out); else passed++;
        total++; if (sel_out !== 2'd0) $display("FAIL rst_sel_out: got %0d expected 0", sel_out); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        set_unit(0, 32'h3F800000, 1'b1, 5'h01, 4'h5);
        valid_in  = 4'b0001;
        ready_out = 1'b1;
        @(negedge clk);
        total++; if (ready_in !== 4'b0001) $display("FAIL t1_ready_in: got %b expected 0001", ready_in); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL t1_valid_early: got %b expected 0", valid_out); else passed++;
        next_cycle();
        valid_in = '0;
        @(negedge clk);
        total++; if (valid_out !== 1'b1) $display("FAIL t1_valid_out: got %b expected 1", valid_out); else passed++;
        total++; if (result_out !== 32'h3F800000) $display("FAIL t1_result: got %h expected 3f800000", result_out); else passed++;
        total++; if (fflags_out !== 5'h01) $display("FAIL t1_fflags: got %h expected 01", fflags_out); else passed++;
        total++; if (has_fflags_out !== 1'b1) $display("FAIL t1_has_fflags: got %b expected 1", has_fflags_out); else passed++;
        total++; if (tag_out !== 4'h5) $display("FAIL t1_tag: got %h expected 5", tag_out); else passed++;
        total++; if (sel_out !== 2'd0) $display("FAIL t1_sel: got %0d expected 0", sel_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL t1_drained: got %b expected 0", valid_out); else passed++;
    endtask

    // All four units valid for 8 cycles: strict rotation with no bubbles.
    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        logic [1:0]   exp_sel;
        do_reset();
        for (int u = 0; u < N; u++) set_unit(u, 32'h1000 + u, 1'b0, 5'(u), 4'(u + 8));
        ready_out = 1'b1;
        for (int c = 0; c < 9; c++) begin
            valid_in = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) begin
                exp_rdy = 4'b0001 << (c % 4);
                total++; if (ready_in !== exp_rdy) $display("FAIL t2_ready_in c%0d: got %b expected %b", c, ready_in, exp_rdy); else passed++;
            end
            if (c >= 1) begin
                exp_sel = 2'((c - 1) % 4);
                total++; if (valid_out !== 1'b1) $display("FAIL t2_bubble c%0d: got %b expected 1", c, valid_out); else passed++;
                total++; if (sel_out !== exp_sel) $display("FAIL t2_sel c%0d: got %0d expected %0d", c, sel_out, exp_sel); else passed++;
                total++; if (result_out !== 32'h1000 + 32'(exp_sel)) $display("FAIL t2_result c%0d: got %h expected %h", c, result_out, 32'h1000 + 32'(exp_sel)); else passed++;
            end
`ifdef FPU_RSP_ARB_PERF_EN
            if (c == 8) begin
                total++; if (perf_conflicts !== 44'd8) $display("FAIL t2_conflicts: got %0d expected 8", perf_conflicts); else passed++;
            end
`endif
            next_cycle();
        end
    endtask

    // Unit 2 streams tags 7,8,9 into a stalled output, then the output drains.
    task automatic test_backpressure();
        do_reset();
        ready_out = 1'b0;
        valid_in  = 4'b0100;
        set_unit(2, 32'h7, 1'b0, 5'h0, 4'd7);
        @(negedge clk);
        total++; if (ready_in !== 4'b0100) $display("FAIL t3_rdy0: got %b expected 0100", ready_in); else passed++;
        next_cycle();
        set_unit(2, 32'h8, 1'b0, 5'h0, 4'd8);
        @(negedge clk);
        total++; if (ready_in !== 4'b0100) $display("FAIL t3_rdy1: got %b expected 0100", ready_in); else passed++;
        next_cycle();
        set_unit(2, 32'h9, 1'b0, 5'h0, 4'd9);
        @(negedge clk);
        total++; if (ready_in !== 4'b0000) $display("FAIL t3_full_rdy: got %b expected 0000", ready_in); else passed++;
        total++; if (tag_out !== 4'd7) $display("FAIL t3_head: got %0d expected 7", tag_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (tag_out !== 4'd7) $display("FAIL t3_head_stable: got %0d expected 7", tag_out); else passed++;
        total++; if (ready_in !== 4'b0000) $display("FAIL t3_full_rdy2: got %b expected 0000", ready_in); else passed++;
        next_cycle();
        ready_out = 1'b1;
        @(negedge clk);
`ifdef FPU_RSP_ARB_PERF_EN
        total++; if (perf_stalls !== 44'd3) $display("FAIL t3_stalls: got %0d expected 3", perf_stalls); else passed++;
`endif
        total++; if (ready_in !== 4'b0000) $display("FAIL t3_pop_no_push: got %b expected 0000", ready_in); else passed++;
        total++; if (tag_out !== 4'd7) $display("FAIL t3_drain7: got %0d expected 7", tag_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (ready_in !== 4'b0100) $display("FAIL t3_rdy_again: got %b expected 0100", ready_in); else passed++;
        total++; if (tag_out !== 4'd8) $display("FAIL t3_drain8: got %0d expected 8", tag_out); else passed++;
        next_cycle();
        valid_in = '0;
        @(negedge clk);
        total++; if (valid_out !== 1'b1 || tag_out !== 4'd9) $display("FAIL t3_drain9: got v%b tag %0d expected v1 tag 9", valid_out, tag_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL t3_empty: got %b expected 0", valid_out); else passed++;
    endtask

    // Full buffer: a pop and a valid unit 1 in the same cycle gives no push.
    task automatic test_full_pop();
        do_reset();
        ready_out = 1'b0;
        valid_in  = 4'b0010;
        set_unit(1, 32'h1, 1'b0, 5'h0, 4'd1);
        next_cycle();
        set_unit(1, 32'h2, 1'b0, 5'h0, 4'd2);
        next_cycle();
        set_unit(1, 32'h3, 1'b0, 5'h0, 4'd3);
        ready_out = 1'b1;
        @(negedge clk);
        total++; if (ready_in !== 4'b0000) $display("FAIL t4_no_push: got %b expected 0000", ready_in); else passed++;
        total++; if (tag_out !== 4'd1) $display("FAIL t4_head1: got %0d expected 1", tag_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (ready_in !== 4'b0010) $display("FAIL t4_rdy_next: got %b expected 0010", ready_in); else passed++;
        total++; if (tag_out !== 4'd2) $display("FAIL t4_head2: got %0d expected 2", tag_out); else passed++;
        next_cycle();
        valid_in = '0;
        @(negedge clk);
        total++; if (tag_out !== 4'd3) $display("FAIL t4_head3: got %0d expected 3", tag_out); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL t4_empty: got %b expected 0", valid_out); else passed++;
    endtask

    // Reset with a full buffer and a moved pointer clears everything.
    task automatic test_reset_full();
        do_reset();
        ready_out = 1'b0;
        valid_in  = 4'b0100;
        set_unit(2, 32'hAB, 1'b1, 5'h1F, 4'd4);
        next_cycle();
        next_cycle();
        reset    = 1'b1;
        valid_in = 4'b0110;
        set_unit(1, 32'hCD, 1'b0, 5'h2, 4'd6);
        @(negedge clk);
        total++; if (ready_in !== 4'b0000) $display("FAIL t5_rdy_in_reset: got %b expected 0000", ready_in); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (valid_out !== 1'b0) $display("FAIL t5_valid: got %b expected 0", valid_out); else passed++;
        total++; if (ready_in !== 4'b0000) $display("FAIL t5_rdy: got %b expected 0000", ready_in); else passed++;
        total++; if (result_out !== 32'h0 || tag_out !== 4'd0) $display("FAIL t5_data: got %h/%0d expected 0/0", result_out, tag_out); else passed++;
        next_cycle();
        reset     = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        total++; if (ready_in !== 4'b0010) $display("FAIL t5_first_grant: got %b expected 0010", ready_in); else passed++;
        next_cycle();
        valid_in = '0;
        @(negedge clk);
        total++; if (sel_out !== 2'd1 || tag_out !== 4'd6) $display("FAIL t5_out: got sel %0d tag %0d expected sel 1 tag 6", sel_out, tag_out); else passed++;
        next_cycle();
    endtask

    // Pointer at 3 with units 3 and 0 valid: grants alternate with wrap-around.
    task automatic test_wrap();
        logic [1:0] exp_sel;
        do_reset();
        ready_out = 1'b1;
        valid_in  = 4'b0100;
        set_unit(2, 32'h2, 1'b0, 5'h0, 4'd2);
        next_cycle();
        valid_in = '0;
        next_cycle();
        set_unit(0, 32'h10, 1'b0, 5'h0, 4'd0);
        set_unit(3, 32'h13, 1'b0, 5'h0, 4'd3);
        for (int c = 0; c < 5; c++) begin
            valid_in = (c < 4) ? 4'b1001 : 4'b0000;
            @(negedge clk);
            if (c < 4) begin
                total++; if (ready_in !== ((c % 2 == 0) ? 4'b1000 : 4'b0001))
                    $display("FAIL t6_rdy c%0d: got %b expected %b", c, ready_in, (c % 2 == 0) ? 4'b1000 : 4'b0001);
                else passed++;
            end
            if (c >= 1) begin
                exp_sel = (c % 2 == 1) ? 2'd3 : 2'd0;
                total++; if (sel_out !== exp_sel || valid_out !== 1'b1) $display("FAIL t6_sel c%0d: got %0d expected %0d", c, sel_out, exp_sel); else passed++;
            end
            next_cycle();
        end
    endtask

    // Test sequence and final report
    initial begin
        passed        = 0;
        total         = 0;
        reset         = 1'b1;
        valid_in      = '0;
        ready_out     = 1'b0;
        result_in     = '0;
        has_fflags_in = '0;
        fflags_in     = '0;
        tag_in        = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full_pop();
        test_reset_full();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
